// File: rtl/mfcc_top_if.sv
`default_nettype none
// ============================================================================
// Module      : mfcc_top_if
// Description : Bundle of the start/stage handshake, result-memory write port
//               and system read port of the MFCC top-level sequencer.
// Revision    : 1.0
// ============================================================================
interface mfcc_top_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  top_state_en;
  logic [6:0]            frame_num;
  logic [8:0]            stage_done;
  logic                  res_wr_en;
  logic [ADDR_WIDTH-1:0] res_wr_addr;
  logic [DATA_WIDTH-1:0] res_wr_data;
  logic [ADDR_WIDTH-1:0] system_result_4_mem_addr;
  logic                  system_result_4_mem_addr_sel;
  logic [8:0]            stage_start;
  logic [6:0]            cur_frame;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result_data_out;
  logic                  finish_flag;

  // System / engine side: drives requests, done bits and memory traffic
  modport master (
    output top_state_en, frame_num, stage_done,
    output res_wr_en, res_wr_addr, res_wr_data,
    output system_result_4_mem_addr, system_result_4_mem_addr_sel,
    input  stage_start, cur_frame, busy, result_data_out, finish_flag
  );

  // Sequencer side
  modport slave (
    input  top_state_en, frame_num, stage_done,
    input  res_wr_en, res_wr_addr, res_wr_data,
    input  system_result_4_mem_addr, system_result_4_mem_addr_sel,
    output stage_start, cur_frame, busy, result_data_out, finish_flag
  );
endinterface
`default_nettype wire

// File: rtl/mfcc_top.sv
`default_nettype none
// ============================================================================
// Module      : mfcc_top
// Description : MFCC accelerator sequencer. Walks the seven per-frame engines
//               over all frames, then the delta and delta-delta passes over
//               frames 2..N-3, and owns the 32-bit result memory.
// Revision    : 1.0
// ============================================================================
module mfcc_top #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  wire logic   clk,
  input  wire logic   rst_n,   // active-high synchronous reset
  mfcc_top_if.slave   bus
);

  // Stage states carry their stage index as encoding so the index doubles as
  // the bit position in stage_start / stage_done.
  typedef enum logic [3:0] {
    ST_STAGE0 = 4'd0,
    ST_STAGE1 = 4'd1,
    ST_STAGE2 = 4'd2,
    ST_STAGE3 = 4'd3,
    ST_STAGE4 = 4'd4,
    ST_STAGE5 = 4'd5,
    ST_STAGE6 = 4'd6,
    ST_STAGE7 = 4'd7,
    ST_STAGE8 = 4'd8,
    ST_IDLE   = 4'd9,
    ST_DONE   = 4'd10
  } state_t;

  state_t                state_q, state_d;
  logic                  en_prev_q, en_prev_d;
  logic [8:0]            stage_start_q, stage_start_d;
  logic [6:0]            cur_frame_q, cur_frame_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  start_edge;
  logic [8:0]            stage_sel;
  logic                  stage_hit;
  logic [7:0]            frame_p1;
  logic [7:0]            frame_p3;
  logic [7:0]            n_ext;

  assign start_edge = bus.top_state_en & ~en_prev_q;
  // One-hot of the active stage; zero in IDLE/DONE since the shift runs off
  assign stage_sel  = 9'd1 << state_q;
  // A non-zero start register marks the entry cycle, where done is ignored
  assign stage_hit  = (|(bus.stage_done & stage_sel)) & ~(|stage_start_q);
  assign frame_p1   = {1'b0, cur_frame_q} + 8'd1;
  assign frame_p3   = {1'b0, cur_frame_q} + 8'd3;
  assign n_ext      = {1'b0, bus.frame_num};

  // Next-state, frame counter and start-pulse generation
  always_comb begin
    state_d       = state_q;
    en_prev_d     = bus.top_state_en;
    stage_start_d = '0;
    cur_frame_d   = cur_frame_q;
    busy_d        = busy_q;
    finish_d      = finish_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          cur_frame_d = '0;
          if (bus.frame_num == 7'd0) begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            finish_d = 1'b1;
          end else begin
            state_d       = ST_STAGE0;
            busy_d        = 1'b1;
            finish_d      = 1'b0;
            stage_start_d = 9'h001;
          end
        end
      end
      ST_STAGE0, ST_STAGE1, ST_STAGE2, ST_STAGE3, ST_STAGE4, ST_STAGE5: begin
        if (stage_hit) begin
          state_d       = state_t'(state_q + 4'd1);
          stage_start_d = stage_sel << 1;
        end
      end
      ST_STAGE6: begin
        if (stage_hit) begin
          if (frame_p1 < n_ext) begin
            cur_frame_d   = frame_p1[6:0];
            state_d       = ST_STAGE0;
            stage_start_d = 9'h001;
          end else if (bus.frame_num >= 7'd5) begin
            cur_frame_d   = 7'd2;
            state_d       = ST_STAGE7;
            stage_start_d = 9'h080;
          end else begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            finish_d = 1'b1;
          end
        end
      end
      ST_STAGE7: begin
        if (stage_hit) begin
          if (frame_p3 < n_ext) begin
            cur_frame_d   = frame_p1[6:0];
            stage_start_d = 9'h080;
          end else begin
            cur_frame_d   = 7'd2;
            state_d       = ST_STAGE8;
            stage_start_d = 9'h100;
          end
        end
      end
      ST_STAGE8: begin
        if (stage_hit) begin
          if (frame_p3 < n_ext) begin
            cur_frame_d   = frame_p1[6:0];
            stage_start_d = 9'h100;
          end else begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            finish_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= ST_IDLE;
      en_prev_q     <= 1'b0;
      stage_start_q <= '0;
      cur_frame_q   <= '0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_prev_q     <= en_prev_d;
      stage_start_q <= stage_start_d;
      cur_frame_q   <= cur_frame_d;
      busy_q        <= busy_d;
      finish_q      <= finish_d;
    end
  end

  // Engine write port, open in every cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.res_wr_en) begin
      mem[bus.res_wr_addr] <= bus.res_wr_data;
    end
  end

  // System read: sel low loads the addressed word, sel high holds
  always_comb begin
    result_d = result_q;
    if (!bus.system_result_4_mem_addr_sel) begin
      result_d = mem[bus.system_result_4_mem_addr];
    end
  end

  // Read data register; sampling pre-write contents gives read-before-write
  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.stage_start     = stage_start_q;
  assign bus.cur_frame       = cur_frame_q;
  assign bus.busy            = busy_q;
  assign bus.finish_flag     = finish_q;
  assign bus.result_data_out = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mfcc_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfcc_top
// Description : Self-checking bench for mfcc_top: expected start pulses and
//               read data are queued when stimulus is driven and popped when
//               the design responds.
// Revision    : 1.0
// ============================================================================
module tb_mfcc_top;
  localparam int DW = 32;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mfcc_top_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mfcc_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int stage; int frame; } pulse_t;
  typedef struct { bit we; logic [AW-1:0] wa; logic [DW-1:0] wd; bit sel; logic [AW-1:0] ra; } mstep_t;

  pulse_t        exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] mem_model [int];
  logic [DW-1:0] last_rd;
  int checks = 0;
  int failures = 0;

  task automatic apply_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (bus.stage_start !== 9'h000) begin failures++; $display("FAIL reset_stage_start got=%h exp=000", bus.stage_start); end
    checks++; if (bus.cur_frame !== 7'd0) begin failures++; $display("FAIL reset_cur_frame got=%0d exp=0", bus.cur_frame); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.finish_flag !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", bus.finish_flag); end
    checks++; if (bus.result_data_out !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_data_out); end
  endtask

  task automatic test_memory;
    mstep_t steps[9];
    logic [DW-1:0] want;
    steps = '{
      '{1'b1, 14'h0085, 32'h3F80_0000, 1'b1, 14'h0000},
      '{1'b1, 14'h0100, 32'h1234_5678, 1'b1, 14'h0000},
      '{1'b0, 14'h0000, 32'h0,         1'b0, 14'h0085},
      '{1'b0, 14'h0000, 32'h0,         1'b1, 14'h0100},
      '{1'b0, 14'h0000, 32'h0,         1'b1, 14'h0100},
      '{1'b0, 14'h0000, 32'h0,         1'b0, 14'h0100},
      '{1'b1, 14'h0085, 32'hDEAD_BEEF, 1'b0, 14'h0085},
      '{1'b0, 14'h0000, 32'h0,         1'b0, 14'h0085},
      '{1'b0, 14'h0000, 32'h0,         1'b1, 14'h0085}
    };
    for (int s = 0; s < 9; s++) begin
      bus.res_wr_en                    = steps[s].we;
      bus.res_wr_addr                  = steps[s].wa;
      bus.res_wr_data                  = steps[s].wd;
      bus.system_result_4_mem_addr_sel = steps[s].sel;
      bus.system_result_4_mem_addr     = steps[s].ra;
      if (!steps[s].sel) last_rd = mem_model[int'(steps[s].ra)];
      rd_q.push_back(last_rd);
      if (steps[s].we) mem_model[int'(steps[s].wa)] = steps[s].wd;
      @(negedge clk);
      want = rd_q.pop_front();
      checks++;
      if (bus.result_data_out !== want) begin
        failures++;
        $display("FAIL mem_step%0d got=%h exp=%h", s, bus.result_data_out, want);
      end
    end
    bus.res_wr_en = 1'b0;
    bus.system_result_4_mem_addr_sel = 1'b1;
  endtask

  // Full run: hold = cycles the start request stays high, repulse = loop
  // cycle of an extra mid-run start pulse, ab_* = pulse at which to reset.
  task automatic do_run(input int n, input int dly, input int hold, input int repulse,
                        input int ab_stage, input int ab_frame);
    int cnt = 0;
    int since = 100;
    logic [8:0] pend = '0;
    bit finished = 0;
    bit aborted = 0;
    pulse_t e;
    exp_q.delete();
    for (int f = 0; f < n; f++)
      for (int k = 0; k < 7; k++) exp_q.push_back('{k, f});
    if (n >= 5) begin
      for (int f = 2; f <= n - 3; f++) exp_q.push_back('{7, f});
      for (int f = 2; f <= n - 3; f++) exp_q.push_back('{8, f});
    end
    bus.frame_num = 7'(n);
    bus.top_state_en = 1'b1;
    for (int i = 0; i < 4000 && !finished && !aborted; i++) begin
      @(negedge clk);
      bus.top_state_en = (i + 1 < hold) || (i == repulse);
      bus.stage_done = '0;
      since++;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin bus.stage_done = pend; since = 0; end
      end
      if (i == 0) begin
        checks++;
        if (bus.busy !== (n != 0) || bus.finish_flag !== (n == 0)) begin
          failures++;
          $display("FAIL start_latency n=%0d busy=%b finish=%b exp_busy=%b", n, bus.busy, bus.finish_flag, n != 0);
        end
      end
      if (bus.stage_start !== 9'h000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_pulse n=%0d got=%h frame=%0d", n, bus.stage_start, bus.cur_frame);
        end else begin
          e = exp_q.pop_front();
          if (bus.stage_start !== (9'd1 << e.stage) || bus.cur_frame !== 7'(e.frame)) begin
            failures++;
            $display("FAIL pulse n=%0d got=%h/f%0d exp=%h/f%0d", n, bus.stage_start, bus.cur_frame,
                     9'd1 << e.stage, e.frame);
          end
          if (e.stage == ab_stage && e.frame == ab_frame) begin
            rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.stage_start !== 9'h0 || bus.cur_frame !== 7'd0 || bus.busy !== 1'b0 ||
                bus.finish_flag !== 1'b0 || bus.result_data_out !== 32'h0) begin
              failures++;
              $display("FAIL abort_outputs got=%h/%0d/%b/%b/%h exp=all zero", bus.stage_start,
                       bus.cur_frame, bus.busy, bus.finish_flag, bus.result_data_out);
            end
            rst_n = 1'b0;
            bus.top_state_en = 1'b0;
            last_rd = '0;
            repeat (5) begin
              @(negedge clk);
              checks++;
              if (bus.stage_start !== 9'h0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet got start=%h busy=%b exp=0/0", bus.stage_start, bus.busy);
              end
            end
            exp_q.delete();
            aborted = 1;
          end
        end
        cnt = dly;
        pend = bus.stage_start;
      end
      if (!aborted && bus.finish_flag === 1'b1) begin
        finished = 1;
        checks++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0 || (n > 0 && since != 1)) begin
          failures++;
          $display("FAIL finish n=%0d left=%0d busy=%b since_done=%0d exp=0/0/1", n, exp_q.size(), bus.busy, since);
        end
      end
    end
    bus.stage_done = '0;
    bus.top_state_en = 1'b0;
    if (!aborted) begin
      if (!finished) begin
        checks++; failures++;
        $display("FAIL run_timeout n=%0d left=%0d exp=finish", n, exp_q.size());
      end else begin
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.stage_start !== 9'h0 || bus.finish_flag !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done got start=%h finish=%b busy=%b exp=000/1/0", bus.stage_start, bus.finish_flag, bus.busy);
          end
        end
      end
    end
  endtask

  task automatic test_single_frame;  do_run(1, 3, 1, -1, -1, -1); endtask
  task automatic test_six_frames;    do_run(6, 1, 1, -1, -1, -1); endtask
  task automatic test_zero_frames;   do_run(0, 1, 1, -1, -1, -1); endtask

  task automatic test_start_filter;
    do_run(6, 2, 10, 40, -1, -1);
    do_run(5, 1, 1, -1, -1, -1);
  endtask

  task automatic test_spurious_done;
    bit got2 = 0;
    logic [8:0] pend = '0;
    apply_reset();
    bus.frame_num = 7'd1;
    bus.top_state_en = 1'b1;
    for (int i = 0; i < 50 && !got2; i++) begin
      @(negedge clk);
      bus.top_state_en = 1'b0;
      bus.stage_done = pend;
      pend = '0;
      if (bus.stage_start == 9'h001 || bus.stage_start == 9'h002) pend = bus.stage_start;
      else if (bus.stage_start == 9'h004) got2 = 1;
    end
    checks++;
    if (!got2) begin
      failures++;
      $display("FAIL spur_reach_fft got=none exp=stage_start 004");
    end
    bus.stage_done = 9'h1FF;
    repeat (4) begin
      @(negedge clk);
      bus.stage_done = 9'h1FB;
      checks++;
      if (bus.stage_start !== 9'h000 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL spur_hold got start=%h busy=%b exp=000/1", bus.stage_start, bus.busy);
      end
    end
    bus.stage_done = 9'h004;
    @(negedge clk);
    bus.stage_done = '0;
    checks++;
    if (bus.stage_start !== 9'h008 || bus.cur_frame !== 7'd0) begin
      failures++;
      $display("FAIL spur_advance got=%h/f%0d exp=008/f0", bus.stage_start, bus.cur_frame);
    end
    apply_reset();
  endtask

  task automatic test_reset_abort;
    do_run(6, 1, 1, -1, 4, 3);
    bus.system_result_4_mem_addr_sel = 1'b0;
    bus.system_result_4_mem_addr = 14'h0085;
    rd_q.push_back(mem_model[32'h85]);
    @(negedge clk);
    bus.system_result_4_mem_addr_sel = 1'b1;
    last_rd = rd_q.pop_front();
    checks++;
    if (bus.result_data_out !== last_rd) begin
      failures++;
      $display("FAIL mem_retained got=%h exp=%h", bus.result_data_out, last_rd);
    end
  endtask

  initial begin
    bus.top_state_en = 1'b0;
    bus.frame_num = 7'd0;
    bus.stage_done = '0;
    bus.res_wr_en = 1'b0;
    bus.res_wr_addr = '0;
    bus.res_wr_data = '0;
    bus.system_result_4_mem_addr = '0;
    bus.system_result_4_mem_addr_sel = 1'b1;
    test_reset();
    test_memory();
    test_single_frame();
    test_six_frames();
    test_zero_frames();
    test_start_filter();
    test_spurious_done();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
